fir_wb_dma: RTL and testbench

FIR_WB_DMA -- requirements
Module: fir_wb_dma

---
 rtl/fir_wb_dma_pkg.sv | 33 +++
 rtl/fir_wb_dma_if.sv | 21 ++
 rtl/wb_master_port.sv | 73 +++++++
 rtl/fir_wb_dma.sv | 113 +++++++++++
 tb/tb_fir_wb_dma.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_wb_dma_pkg.sv
// Shared types and FIR register map for the FIR Wishbone DMA block.
// Build option: define FIR_WB_DMA_TIMEOUT_EN to enable the bus-timeout watchdog.
package fir_wb_dma_pkg;

  typedef enum logic [3:0] {
    IDLE, CFG_LEN, CFG_START, RD_SRC, WR_X, RD_Y, WR_DST, POLL, FIN, ERR
  } state_e;

  // FIR register offsets relative to FIR_BASE
  localparam logic [31:0] REG_CTRL = 32'h04;
  localparam logic [31:0] REG_LEN  = 32'h10;
  localparam logic [31:0] REG_X    = 32'h80;
  localparam logic [31:0] REG_Y    = 32'h88;

  localparam int AP_DONE_BIT = 1;

`ifdef FIR_WB_DMA_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xfer_t;

  function automatic logic is_xfer_state(state_e s);
    return s inside {CFG_LEN, CFG_START, RD_SRC, WR_X, RD_Y, WR_DST, POLL};
  endfunction

endpackage

// File: rtl/fir_wb_dma_if.sv
// Wishbone classic bus between the DMA master and the system fabric.
interface fir_wb_dma_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_master_port.sv
// Single-transfer Wishbone classic engine: one request in, one ack-qualified
// completion (or timeout, when FIR_WB_DMA_TIMEOUT_EN is defined) out.
module wb_master_port
  import fir_wb_dma_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  xfer_t        xfer,
  output logic         ready,
  output logic         xdone,
  output logic         xto,
  output logic [31:0]  rdata,
  fir_wb_dma_if.master wbm
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] tcnt;
  logic          timed_out;

  // A request is only taken while the bus is down, so dropping cyc after an
  // ack leaves exactly one idle cycle before the next accept edge.
  assign ready     = ~wbm.wbm_cyc_o;
  assign timed_out = TIMEOUT_EN && (tcnt == TW'(TIMEOUT_CYC - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbm.wbm_cyc_o <= 1'b0;
      wbm.wbm_stb_o <= 1'b0;
      wbm.wbm_we_o  <= 1'b0;
      wbm.wbm_sel_o <= 4'h0;
      wbm.wbm_adr_o <= '0;
      wbm.wbm_dat_o <= '0;
      xdone         <= 1'b0;
      xto           <= 1'b0;
      rdata         <= '0;
      tcnt          <= '0;
    end else begin
      xdone <= 1'b0;
      xto   <= 1'b0;
      if (!wbm.wbm_cyc_o) begin
        if (req) begin
          wbm.wbm_cyc_o <= 1'b1;
          wbm.wbm_stb_o <= 1'b1;
          wbm.wbm_we_o  <= xfer.we;
          wbm.wbm_sel_o <= 4'hF;
          wbm.wbm_adr_o <= xfer.adr;
          wbm.wbm_dat_o <= xfer.we ? xfer.dat : 32'h0;
          tcnt          <= '0;
        end
      end else if (wbm.wbm_ack_i || timed_out) begin
        // An ack arriving on the timeout boundary still completes the transfer
        wbm.wbm_cyc_o <= 1'b0;
        wbm.wbm_stb_o <= 1'b0;
        wbm.wbm_we_o  <= 1'b0;
        wbm.wbm_sel_o <= 4'h0;
        wbm.wbm_adr_o <= '0;
        wbm.wbm_dat_o <= '0;
        xdone         <= wbm.wbm_ack_i;
        xto           <= ~wbm.wbm_ack_i;
        if (wbm.wbm_ack_i && !wbm.wbm_we_o) rdata <= wbm.wbm_dat_i;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/fir_wb_dma.sv
// Streams samples from memory through a Wishbone-attached FIR block and back.
// Build option: FIR_WB_DMA_TIMEOUT_EN enables bus timeout and the err flag.
module fir_wb_dma
  import fir_wb_dma_pkg::*;
#(
  parameter logic [31:0] FIR_BASE    = 32'h3200_0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  src_addr,
  input  logic [31:0]  dst_addr,
  input  logic [9:0]   length,
  output logic         busy,
  output logic         done,
  output logic         err,
  fir_wb_dma_if.master wbm
);

  state_e      state, state_next;
  logic [31:0] src_ptr, dst_ptr;
  logic [9:0]  len_q, cnt;
  logic        err_q;

  logic        req, ready, xdone, xto;
  xfer_t       xfer;
  logic [31:0] rdata;

  wb_master_port #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_port (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .xfer  (xfer),
    .ready (ready),
    .xdone (xdone),
    .xto   (xto),
    .rdata (rdata),
    .wbm   (wbm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      len_q   <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        src_ptr <= {src_addr[31:2], 2'b00};
        dst_ptr <= {dst_addr[31:2], 2'b00};
        len_q   <= length;
        cnt     <= '0;
        err_q   <= 1'b0;
      end
      if (xdone && state == RD_SRC) src_ptr <= src_ptr + 32'd4;
      if (xdone && state == WR_DST) begin
        dst_ptr <= dst_ptr + 32'd4;
        cnt     <= cnt + 10'd1;
      end
      if (xto) err_q <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (start) state_next = CFG_LEN;
      CFG_LEN:   if (xdone) state_next = CFG_START;
      CFG_START: if (xdone) state_next = (len_q == 10'd0) ? POLL : RD_SRC;
      RD_SRC:    if (xdone) state_next = WR_X;
      WR_X:      if (xdone) state_next = RD_Y;
      RD_Y:      if (xdone) state_next = WR_DST;
      WR_DST:    if (xdone) state_next = (cnt + 10'd1 == len_q) ? POLL : RD_SRC;
      POLL:      if (xdone) state_next = rdata[AP_DONE_BIT] ? FIN : POLL;
      FIN:       state_next = IDLE;
      ERR:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (xto) state_next = ERR;
  end

  // Requests are decoded from the state being entered so the next transfer
  // launches on the same edge as the transition, keeping the gap to one cycle.
  always_comb begin
    req  = 1'b0;
    xfer = '0;
    if (ready && is_xfer_state(state_next)) begin
      req = 1'b1;
      case (state_next)
        // Only entered on the start cycle, so the length port is still valid
        CFG_LEN:   xfer = '{we: 1'b1, adr: FIR_BASE + REG_LEN,  dat: {22'd0, length}};
        CFG_START: xfer = '{we: 1'b1, adr: FIR_BASE + REG_CTRL, dat: 32'h1};
        RD_SRC:    xfer = '{we: 1'b0, adr: src_ptr,             dat: 32'h0};
        WR_X:      xfer = '{we: 1'b1, adr: FIR_BASE + REG_X,    dat: rdata};
        RD_Y:      xfer = '{we: 1'b0, adr: FIR_BASE + REG_Y,    dat: 32'h0};
        WR_DST:    xfer = '{we: 1'b1, adr: dst_ptr,             dat: rdata};
        POLL:      xfer = '{we: 1'b0, adr: FIR_BASE + REG_CTRL, dat: 32'h0};
        default:   xfer = '0;
      endcase
    end
  end

  assign busy = is_xfer_state(state);
  assign done = (state == FIN);
  assign err  = TIMEOUT_EN & err_q;

endmodule

// File: tb/tb_fir_wb_dma.sv
// Scoreboard bench for fir_wb_dma: a reactive Wishbone slave models memory
// and an echo FIR (y = x + 1) and checks each transfer against a queue.
module tb_fir_wb_dma;

  localparam logic [31:0] BASE = 32'h3200_0000;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] src_addr, dst_addr;
  logic [9:0]  length;
  logic        busy, done, err;

  fir_wb_dma_if bus();

  fir_wb_dma #(.FIR_BASE(BASE), .TIMEOUT_CYC(255)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .wbm      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  bit          no_ack_x = 0;
  int          poll_left = 0;
  bit          first_xfer = 1;
  int          done_cnt = 0;
  logic [31:0] last_x = '0;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  function automatic exp_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    exp_t e;
    e.we = we; e.adr = adr; e.dat = dat;
    return e;
  endfunction

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Slave: acks after ack_delay wait cycles, checks hold stability, idle gap
  // and the expected transfer sequence.
  initial begin : slave
    int          wait_cnt;
    int          gap;
    bit          in_xfer;
    logic        ref_we;
    logic [3:0]  ref_sel;
    logic [31:0] ref_adr, ref_dat;
    exp_t        e;
    wait_cnt = 0; gap = 0; in_xfer = 0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      bus.wbm_ack_i = 1'b0;
      if (bus.wbm_cyc_o && bus.wbm_stb_o && !rst) begin
        if (!in_xfer) begin
          in_xfer = 1; wait_cnt = 0;
          ref_we = bus.wbm_we_o; ref_sel = bus.wbm_sel_o;
          ref_adr = bus.wbm_adr_o; ref_dat = bus.wbm_dat_o;
          if (!first_xfer) begin
            checks++;
            if (gap !== 1) begin
              errors++;
              $display("FAIL idle_gap got %0d cycles want 1 (adr %h)", gap, bus.wbm_adr_o);
            end
          end
          first_xfer = 0;
          checks++;
          if (bus.wbm_sel_o !== 4'hF) begin
            errors++;
            $display("FAIL sel got %h want f", bus.wbm_sel_o);
          end
        end else begin
          checks++;
          if ({bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o} !==
              {ref_we, ref_sel, ref_adr, ref_dat}) begin
            errors++;
            $display("FAIL hold_stable got we=%b adr=%h dat=%h want we=%b adr=%h dat=%h",
                     bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o, ref_we, ref_adr, ref_dat);
          end
        end
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else if (!(no_ack_x && bus.wbm_adr_o == BASE + 32'h80)) begin
          bus.wbm_ack_i = 1'b1;
          in_xfer = 0; gap = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_xfer got we=%b adr=%h dat=%h want none",
                     bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o);
          end else begin
            e = exp_q.pop_front();
            if (bus.wbm_we_o !== e.we || bus.wbm_adr_o !== e.adr || bus.wbm_dat_o !== e.dat) begin
              errors++;
              $display("FAIL xfer got we=%b adr=%h dat=%h want we=%b adr=%h dat=%h",
                       bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o, e.we, e.adr, e.dat);
            end
          end
          if (bus.wbm_we_o) begin
            if (bus.wbm_adr_o == BASE + 32'h80) last_x = bus.wbm_dat_o;
          end else if (bus.wbm_adr_o == BASE + 32'h88) begin
            bus.wbm_dat_i = last_x + 32'd1;
          end else if (bus.wbm_adr_o == BASE + 32'h04) begin
            if (poll_left > 0) begin
              poll_left--;
              bus.wbm_dat_i = 32'h0;
            end else begin
              bus.wbm_dat_i = 32'h2;
            end
          end else begin
            bus.wbm_dat_i = src_word(bus.wbm_adr_o);
          end
        end
      end else begin
        in_xfer = 0;
        gap++;
      end
    end
  end

  task automatic push_job(input logic [31:0] s, input logic [31:0] d, input int n, input int polls);
    logic [31:0] sa, da;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    exp_q.push_back(mk(1'b1, BASE + 32'h10, 32'(n)));
    exp_q.push_back(mk(1'b1, BASE + 32'h04, 32'h1));
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = src_word(sa + 32'(4 * i));
      exp_q.push_back(mk(1'b0, sa + 32'(4 * i), 32'h0));
      exp_q.push_back(mk(1'b1, BASE + 32'h80, w));
      exp_q.push_back(mk(1'b0, BASE + 32'h88, 32'h0));
      exp_q.push_back(mk(1'b1, da + 32'(4 * i), w + 32'd1));
    end
    for (int p = 0; p <= polls; p++) exp_q.push_back(mk(1'b0, BASE + 32'h04, 32'h0));
    poll_left = polls;
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; length = 10'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one job; poke_busy issues a second, bogus start while busy.
  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                         input int polls, input bit poke_busy, input string tag);
    int cyc_cnt;
    push_job(s, d, n, polls);
    first_xfer = 1;
    pulse_start(s, d, n);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start got %b want 1", tag, busy);
    end
    cyc_cnt = 0;
    while (done !== 1'b1 && cyc_cnt < 5000) begin
      start = (poke_busy && cyc_cnt == 8);
      if (start) begin src_addr = 32'h1000_0000; dst_addr = 32'h2000_0000; length = 10'd7; end
      @(negedge clk);
      cyc_cnt++;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_wait got no done want done within 5000 cycles", tag);
    end else begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s done_pulse got done=%b busy=%b want 0 0", tag, done, busy);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover got %0d transfers missing want 0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o} !== 3'b000) begin
      errors++;
      $display("FAIL %s ctl got cyc=%b stb=%b we=%b want 0", tag,
               bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o);
    end
    checks++;
    if (bus.wbm_sel_o !== 4'h0 || bus.wbm_adr_o !== 32'h0 || bus.wbm_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL %s bus got sel=%h adr=%h dat=%h want 0", tag,
               bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o);
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL %s status got busy=%b done=%b err=%b want 0", tag, busy, done, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.wbm_cyc_o !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got cyc=%b busy=%b want 0 0", bus.wbm_cyc_o, busy);
    end
  endtask

  task automatic test_basic();
    ack_delay = 0;
    run_job(32'h3800_0000, 32'h3900_0000, 3, 1, 1'b0, "basic");
  endtask

  task automatic test_ack_delay();
    ack_delay = 5;
    run_job(32'h3800_0100, 32'h3900_0100, 2, 0, 1'b1, "ack_delay");
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (bus.wbm_cyc_o !== 1'b0) begin
        errors++;
        $display("FAIL ignored_start got cyc=%b want 0", bus.wbm_cyc_o);
      end
    end
    ack_delay = 0;
  endtask

  task automatic test_len_zero();
    run_job(32'h3800_0000, 32'h3900_0000, 0, 0, 1'b0, "len_zero");
  endtask

  task automatic test_wrap();
    run_job(32'hFFFF_FFFC, 32'h3900_0203, 2, 0, 1'b0, "wrap");
  endtask

`ifdef FIR_WB_DMA_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int cnt;
    int done_before;
    done_before = done_cnt;
    exp_q.push_back(mk(1'b1, BASE + 32'h10, 32'd1));
    exp_q.push_back(mk(1'b1, BASE + 32'h04, 32'h1));
    exp_q.push_back(mk(1'b0, 32'h3800_0000, 32'h0));
    no_ack_x = 1;
    first_xfer = 1;
    pulse_start(32'h3800_0000, 32'h3900_0000, 1);
    n = 0;
    while (!(bus.wbm_cyc_o === 1'b1 && bus.wbm_adr_o == BASE + 32'h80) && n < 200) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    while (bus.wbm_stb_o === 1'b1 && cnt < 1000) begin
      cnt++;
      start = (cnt == 20);
      if (start) begin src_addr = 32'h1000_0000; length = 10'd0; end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (cnt != 255) begin
      errors++;
      $display("FAIL timeout_len got %0d stb cycles want 255", cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags got err=%b busy=%b want 1 0", err, busy);
    end
    checks++;
    if (done_cnt != done_before || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_done got %0d done pulses %0d pending want 0 0",
               done_cnt - done_before, exp_q.size());
    end
    exp_q.delete();
    no_ack_x = 0;
    run_job(32'h3800_0000, 32'h3900_0000, 0, 0, 1'b0, "after_timeout");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b want 0", err);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    ack_delay = 3;
    push_job(32'h3800_0000, 32'h3900_0000, 1, 0);
    first_xfer = 1;
    pulse_start(32'h3800_0000, 32'h3900_0000, 1);
    n = 0;
    while (!(bus.wbm_cyc_o === 1'b1 && bus.wbm_adr_o == BASE + 32'h88) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL reset_mid_reach got no RD_Y transfer want one within 500 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    rst = 1'b0;
    exp_q.delete();
    ack_delay = 0;
    run_job(32'h3800_0000, 32'h3900_0000, 0, 0, 1'b0, "after_reset");
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog got no finish want finish within 50000 cycles");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_len_zero();
    test_wrap();
`ifdef FIR_WB_DMA_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
